max14866_ctrl: RTL

Master-side serial driver for the MAX14866 16-channel HV mux switch. It accepts a parallel switch word from the sequencer and shifts it MSB-first onto the device's clk/din pins. It then pulses le_n low to latch the word into the switches. While shifting, it captures the device's dout chain, which returns the previously shifted word so firmware can confirm the mux state.

---
 rtl/max14866_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/max14866_ctrl.sv
// Serial master for the MAX14866 HV mux: shifts a switch word MSB-first, pulses le_n, captures dout.
// Optional readback compare (adds `mismatch` output) when MAX14866_READBACK_CHECK_EN is defined.
module max14866_ctrl #(
  parameter int SWITCH_N = 16,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SWITCH_N-1:0] sw_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [SWITCH_N-1:0] readback,
  output logic                mux_clk,
  output logic                mux_din,
  output logic                mux_le_n,
  input  logic                mux_dout
`ifdef MAX14866_READBACK_CHECK_EN
  ,
  output logic                mismatch
`endif
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (SWITCH_N > 1) ? $clog2(SWITCH_N) : 1;
  localparam logic [PW-1:0] PH_MAX  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [BW-1:0] BIT_MAX = BW'(SWITCH_N - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_GAP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [SWITCH_N-1:0] sh_q, sh_d;
  logic [SWITCH_N-1:0] rb_d;
  logic                busy_d, done_d, clk_d, din_d, le_d;
  logic                phase_end;

`ifdef MAX14866_READBACK_CHECK_EN
  logic [SWITCH_N-1:0] frame_q, frame_d, last_q, last_d;
  logic                mm_d;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rb_d      = readback;
    busy_d    = busy;
    done_d    = 1'b0;
    clk_d     = mux_clk;
    din_d     = mux_din;
    le_d      = mux_le_n;
    phase_end = (phase_q == '0);
`ifdef MAX14866_READBACK_CHECK_EN
    frame_d   = frame_q;
    last_d    = last_q;
    mm_d      = mismatch;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT_LO;
          busy_d  = 1'b1;
          din_d   = sw_data[SWITCH_N-1];
          sh_d    = sw_data << 1;
          phase_d = PH_MAX;
          bit_d   = BIT_MAX;
`ifdef MAX14866_READBACK_CHECK_EN
          frame_d = sw_data;
`endif
        end
      end
      S_SHIFT_LO: begin
        if (phase_end) begin
          state_d = S_SHIFT_HI;
          clk_d   = 1'b1;
          phase_d = PH_MAX;
        end else phase_d = phase_q - PH_ONE;
      end
      S_SHIFT_HI: begin
        if (phase_end) begin
          // dout lags by one device clock, so this sample is the old word's next bit
          clk_d   = 1'b0;
          rb_d    = {readback[SWITCH_N-2:0], mux_dout};
          phase_d = PH_MAX;
          if (bit_q == '0) begin
            state_d = S_LATCH;
            din_d   = 1'b0;
            le_d    = 1'b0;
          end else begin
            state_d = S_SHIFT_LO;
            din_d   = sh_q[SWITCH_N-1];
            sh_d    = sh_q << 1;
            bit_d   = bit_q - BIT_ONE;
          end
        end else phase_d = phase_q - PH_ONE;
      end
      S_LATCH: begin
        if (phase_end) begin
          state_d = S_GAP;
          le_d    = 1'b1;
          phase_d = PH_MAX;
        end else phase_d = phase_q - PH_ONE;
      end
      S_GAP: begin
        if (phase_end) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef MAX14866_READBACK_CHECK_EN
          mm_d    = (readback != last_q);
          last_d  = frame_q;
`endif
        end else phase_d = phase_q - PH_ONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      readback <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mux_clk  <= 1'b0;
      mux_din  <= 1'b0;
      mux_le_n <= 1'b1;
`ifdef MAX14866_READBACK_CHECK_EN
      frame_q  <= '0;
      last_q   <= '0;
      mismatch <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      readback <= rb_d;
      busy     <= busy_d;
      done     <= done_d;
      mux_clk  <= clk_d;
      mux_din  <= din_d;
      mux_le_n <= le_d;
`ifdef MAX14866_READBACK_CHECK_EN
      frame_q  <= frame_d;
      last_q   <= last_d;
      mismatch <= mm_d;
`endif
    end
  end

endmodule
